pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Receive-side companion to the PWM generator. It samples an external PWM line and measures the period and high time in clk cycles. It quantises the duty cycle to the same 3-bit speed code the generator accepts. The block sits behind a dedicated input pin in a tt_um top, so a generator's output can be looped back and checked on-chip.

Parameters:
CNT_W, 16, width of the period and high-time counters and outputs; minimum 4.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
enable  input  1  measurement enable
pwm_in  input  1  asynchronous PWM line
period  output  CNT_W  last measured period in clk cycles
high_time  output  CNT_W  last measured high time in clk cycles
duty_code  output  3  min(7, floor(8*high_time/period))
valid  output  1  one-cycle pulse when duty_code/period/high_time are new
timeout  output  1  level: no rising edge seen within 2^CNT_W-1 cycles

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - period=0, high_time=0, duty_code=0, valid=0, timeout=0.
  - Synchroniser flops=0, counters=0, disarmed, divider IDLE.
  - Applies mid-division: the in-progress result is discarded.
- Input path:
  - pwm_in passes through a 2-flop synchroniser, giving lvl.
  - A third flop, lvl_d, drives edge detection: rise = lvl & ~lvl_d.
  - A pin transition reaches rise 2-3 cycles later.
- Counters (enable=1):
  - Cycle with rise: period_cnt<=1; high_cnt<=1.
  - Other cycles: period_cnt increments, saturating at all-ones; high_cnt increments while lvl=1.
- Capture:
  - First rise after reset, after enable rising, or after a timeout only arms the block. No capture and no valid.
  - Each armed rise: period<=period_cnt, high_time<=high_cnt. The divider is loaded in the same cycle.
  - Example: a generator with 8-cycle period and 3 high cycles yields period=8, high_time=3.
- Divider FSM:
  - States: IDLE, DIV, DONE.
  - Restoring division computes floor(8*high/period) one quotient bit per cycle, MSB first.
  - Each step: r=2r; if r>=period then r-=period and bit=1.
  - The remainder register is CNT_W+1 bits.
  - Sequence: IDLE -> DIV (3 cycles) -> DONE.
  - In DONE: duty_code<=quotient, saturated to 7; valid=1 for exactly one cycle; then back to IDLE.
  - With capture on edge E, valid is high in cycle E+4.
- Rise during DIV: the new capture overwrites period/high_time and restarts the divider. The aborted result produces no valid.
- Timeout:
  - Trigger: period_cnt reaches all-ones while enable=1 and no rise occurs.
  - Action: timeout<=1. duty_code<=7 if lvl=1, else 0. period and high_time hold. One valid pulse. Block disarms.
  - The counter stays saturated, with no repeated valid.
  - timeout clears on the next rise, which arms only.
- enable=0:
  - Counters cleared, disarmed, divider forced to IDLE (in-progress division dropped), valid=0.
  - period, high_time, duty_code and timeout hold their values. The synchroniser keeps running.
- period=0 never reaches the divider, because captures always have period>=2.

Decomposition:
- Shared package pwm_pkg: DUTY_W=3 (shared with the generator's speed input), the divider state enum typedef {IDLE, DIV, DONE}, and DIV_STEPS=3.
- Sub-module pwm_duty_div: start/busy/done handshake, inputs high and period, output a 3-bit saturated quotient. Reusable for self-check in the generator bench.
- Synchroniser and counters stay inline in pwm_capture.

Test Plan:
- Period 8 / high 3 waveform, enable=1: first rise arms; the second gives period=8, high_time=3, duty_code=3, with valid at edge+4. It repeats every 8 cycles.
- Period 10 / high 5 -> duty_code=4; period 8 / high 7 -> duty_code=7; period 16 / high 1 -> duty_code=0.
- CNT_W=8, pwm_in held low 300 cycles after arming:
  - After 255 cycles without a rise, timeout=1, duty_code=0, one valid.
  - A subsequent rise clears timeout and only arms.
  - Repeat with pwm_in held high: duty_code=7.
- Period 3 / high 1 waveform: rises every 3 cycles land mid-DIV. Only the restarted divisions complete, and no valid is issued for aborted ones. Check no lock-up.
- enable dropped mid-measurement for 5 cycles, then raised: outputs hold, no valid while low. The first rise after re-enable only arms, and the second rise produces a correct capture.
- rst_n=0 for one cycle during DIV: all outputs 0 next cycle, no valid. The block re-arms on the next rise.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

    localparam int unsigned DUTY_W    = 3;
    localparam int unsigned DIV_STEPS = 3;
    localparam int unsigned STEP_W    = 2;

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider: quotient = min(7, floor(8*high/period)), one bit per cycle, MSB first.
// done_c/quotient_c are look-ahead: they are valid in the cycle of the last DIV step,
// so a consumer can register the result in the same edge the FSM enters DONE.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  high,
    input  logic [CNT_W-1:0]  period,
    output logic              busy,
    output logic              done_c,
    output logic [DUTY_W-1:0] quotient_c
);

    localparam int unsigned REM_W = CNT_W + 1;

    div_state_t         state;
    div_state_t         state_n;
    logic [REM_W-1:0]   rem;
    logic [REM_W-1:0]   rem_n;
    logic [CNT_W-1:0]   den;
    logic [CNT_W-1:0]   den_n;
    logic [DUTY_W-1:0]  quo;
    logic [DUTY_W-1:0]  quo_n;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_n;
    logic               sat;
    logic               sat_n;

    logic [REM_W-1:0]   rem_sh;
    logic               ge;
    logic [REM_W-1:0]   rem_step;
    logic [DUTY_W-1:0]  quo_step;

    // One restoring step on the current remainder
    always_comb begin
        rem_sh   = {rem[CNT_W-1:0], 1'b0};
        ge       = (rem_sh >= {1'b0, den});
        rem_step = ge ? (rem_sh - {1'b0, den}) : rem_sh;
        quo_step = {quo[DUTY_W-2:0], ge};
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            den   <= '0;
            quo   <= '0;
            step  <= '0;
            sat   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            den   <= den_n;
            quo   <= quo_n;
            step  <= step_n;
            sat   <= sat_n;
            busy  <= (state_n == DIV);
        end
    end

    // Next state: clear wins, a start always (re)loads, otherwise step through DIV
    always_comb begin
        state_n    = state;
        rem_n      = rem;
        den_n      = den;
        quo_n      = quo;
        step_n     = step;
        sat_n      = sat;
        done_c     = 1'b0;
        quotient_c = sat ? DUTY_MAX : quo_step;

        if (clear) begin
            state_n = IDLE;
        end else if (start) begin
            state_n = DIV;
            rem_n   = {1'b0, high};
            den_n   = period;
            quo_n   = '0;
            step_n  = '0;
            sat_n   = (high >= period);
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                DIV: begin
                    rem_n  = rem_step;
                    quo_n  = quo_step;
                    step_n = step + STEP_W'(1);
                    if (step == STEP_W'(DIV_STEPS - 1)) begin
                        state_n = DONE;
                        done_c  = 1'b1;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM line and quantises the duty to 3 bits.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty_code,
    output logic              valid,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              sync1;
    logic              lvl;
    logic              lvl_d;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  high_cnt;
    logic              armed;

    logic              rise;
    logic              cnt_full;
    logic              cap;
    logic              to_hit;
    logic              div_busy;
    logic              div_done_c;
    logic [DUTY_W-1:0] div_quotient_c;

    assign rise     = lvl & ~lvl_d;
    assign cnt_full = (period_cnt == CNT_MAX);
    assign cap      = enable & rise & armed;
    // Fires once: timeout stays set (and the counter saturated) until the next rise
    assign to_hit   = enable & ~rise & cnt_full & ~timeout & ~div_busy;

    // Two-flop synchroniser plus edge-detect delay; runs regardless of enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            lvl   <= sync1;
            lvl_d <= lvl;
        end
    end

    // Period/high counters and arming
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            armed      <= 1'b0;
        end else if (!enable) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            armed      <= 1'b0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
            armed      <= 1'b1;
        end else begin
            if (!cnt_full) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end
            if (lvl && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + CNT_W'(1);
            end
            if (to_hit) begin
                armed <= 1'b0;
            end
        end
    end

    // Captured results, duty code, valid pulse and timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period    <= '0;
            high_time <= '0;
            duty_code <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (enable) begin
                if (cap) begin
                    period    <= period_cnt;
                    high_time <= high_cnt;
                end
                if (rise) begin
                    timeout <= 1'b0;
                end
                if (div_done_c) begin
                    duty_code <= div_quotient_c;
                    valid     <= 1'b1;
                end
                if (to_hit) begin
                    timeout   <= 1'b1;
                    duty_code <= lvl ? DUTY_MAX : '0;
                    valid     <= 1'b1;
                end
            end
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (~enable),
        .start      (cap),
        .high       (high_cnt),
        .period     (period_cnt),
        .busy       (div_busy),
        .done_c     (div_done_c),
        .quotient_c (div_quotient_c)
    );

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveform table, scoreboard of expected valid pulses, corner sequences.
module tb_pwm_capture;

    localparam int unsigned CNT_W = 8;
    localparam int TO_LAT = (1 << CNT_W) + 2;  // pin rise drive -> timeout valid
    localparam int CAP_LAT = 6;                // pin rise drive -> capture valid

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [2:0]       duty_code;
    logic             valid;
    logic             timeout;

    pwm_capture #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .duty_code (duty_code),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int period;
        int high;
        int duty;
        int timeout;
    } exp_t;

    typedef struct {
        int per;
        int hi;
        int n;
        int duty;
    } vec_t;

    exp_t q[$];
    vec_t vecs[7];

    bit armed = 1'b0;
    int last_rise = 0;
    int last_hi = 0;
    int cur_period = 0;
    int cur_high = 0;
    int cur_duty = 0;
    int cur_to = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model of what a pin rise driven at cycle c should produce
    function automatic void rise_event(input int c);
        exp_t e;
        int gap;
        if (armed) begin
            gap = c - last_rise;
            if (gap <= 3 && q.size() > 0 && q[$].cyc == last_rise + CAP_LAT && q[$].timeout == 0)
                void'(q.pop_back());
            e.cyc     = c + CAP_LAT;
            e.period  = gap;
            e.high    = last_hi;
            e.duty    = (8 * last_hi) / gap;
            if (e.duty > 7) e.duty = 7;
            e.timeout = 0;
            q.push_back(e);
            cur_period = gap;
            cur_high   = last_hi;
        end
        armed     = 1'b1;
        last_rise = c;
        cur_to    = 0;
    endfunction

    function automatic void expect_timeout(input int lvl_high);
        exp_t e;
        e.cyc     = last_rise + TO_LAT;
        e.period  = cur_period;
        e.high    = cur_high;
        e.duty    = lvl_high ? 7 : 0;
        e.timeout = 1;
        q.push_back(e);
        armed = 1'b0;
    endfunction

    task automatic pulse(input int per, input int hi);
        rise_event(cyc);
        last_hi = hi;
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(per - hi);
    endtask

    task automatic check_outputs(input string tag, input int p, input int h, input int d, input int t);
        chk({tag, "_period"}, int'(period), p);
        chk({tag, "_high"}, int'(high_time), h);
        chk({tag, "_duty"}, int'(duty_code), d);
        chk({tag, "_timeout"}, int'(timeout), t);
    endtask

    // Pops the scoreboard on every valid pulse and flags valids that are missing or extra
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid) begin
                if (q.size() == 0) begin
                    chk("valid_unexpected", int'(valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("valid_period", int'(period), e.period);
                    chk("valid_high", int'(high_time), e.high);
                    chk("valid_duty", int'(duty_code), e.duty);
                    chk("valid_timeout", int'(timeout), e.timeout);
                    cur_duty = e.duty;
                    cur_to   = e.timeout;
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                chk("valid_missing", int'(valid), 1);
                void'(q.pop_front());
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;

        vecs[0] = '{per: 8,  hi: 3, n: 3, duty: 3};
        vecs[1] = '{per: 10, hi: 5, n: 3, duty: 4};
        vecs[2] = '{per: 8,  hi: 7, n: 3, duty: 7};
        vecs[3] = '{per: 16, hi: 1, n: 3, duty: 0};
        vecs[4] = '{per: 12, hi: 6, n: 3, duty: 4};
        vecs[5] = '{per: 5,  hi: 2, n: 4, duty: 3};
        vecs[6] = '{per: 4,  hi: 1, n: 4, duty: 2};

        fork
            monitor();
        join_none

        tick(3);
        check_outputs("reset", 0, 0, 0, 0);
        chk("reset_valid", int'(valid), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(2);

        // Table-driven steady waveforms
        for (int i = 0; i < 7; i++) begin
            repeat (vecs[i].n) pulse(vecs[i].per, vecs[i].hi);
            tick(8);
            check_outputs($sformatf("vec%0d", i), vecs[i].per, vecs[i].hi, vecs[i].duty, 0);
        end

        // Period 3: every capture is restarted mid-division; only the last completes
        repeat (6) pulse(3, 1);
        tick(10);
        check_outputs("p3", 3, 1, 2, 0);
        repeat (3) pulse(8, 3);
        tick(8);
        check_outputs("p3_recover", 8, 3, 3, 0);

        // Timeout with the line held low
        pulse(8, 3);
        expect_timeout(0);
        tick(292);
        check_outputs("to_low", cur_period, cur_high, 0, 1);

        // Rise clears timeout and only arms; then timeout with the line held high
        rise_event(cyc);
        last_hi = 0;
        pwm_in = 1'b1;
        tick(4);
        chk("to_cleared", int'(timeout), 0);
        expect_timeout(1);
        tick(296);
        check_outputs("to_high", cur_period, cur_high, 7, 1);
        pwm_in = 1'b0;
        tick(6);
        pulse(8, 3);
        chk("to_cleared2", int'(timeout), 0);
        repeat (2) pulse(8, 3);
        tick(8);
        check_outputs("after_to", 8, 3, 3, 0);

        // Enable dropped for 5 cycles mid-measurement
        repeat (2) pulse(16, 4);
        rise_event(cyc);
        last_hi = 4;
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(4);
        enable = 1'b0;
        armed  = 1'b0;
        tick(5);
        check_outputs("en_hold", cur_period, cur_high, cur_duty, cur_to);
        enable = 1'b1;
        tick(8);
        pulse(16, 4);
        pulse(16, 4);
        tick(8);
        check_outputs("en_resume", 16, 4, 2, 0);

        // Reset pulse while the divider is busy
        repeat (2) pulse(10, 2);
        rise_event(cyc);
        last_hi = 2;
        pwm_in = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        if (q.size() > 0) void'(q.pop_back());
        armed = 1'b0;
        cur_period = 0;
        cur_high   = 0;
        cur_duty   = 0;
        cur_to     = 0;
        check_outputs("rst_div", 0, 0, 0, 0);
        chk("rst_div_valid", int'(valid), 0);
        rst_n = 1'b1;
        tick(5);
        repeat (3) pulse(10, 2);
        tick(8);
        check_outputs("rst_rearm", 10, 2, 1, 0);

        tick(10);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
